// File: rtl/dma_pkg.sv
// Shared AXI3 read-channel constants and FSM state type for the DDR -> stream read DMA.
package dma_pkg;
    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [2:0] SIZE_8B       = 3'b011;
    localparam logic [3:0] LEN_16        = 4'hF;
    localparam logic [3:0] CACHE_DEFAULT = 4'b0011;
    localparam logic [2:0] PROT_DEFAULT  = 3'b000;
    localparam int         BURST_BEATS   = 16;
    localparam int         BURST_BYTES   = 128;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/dma_stream_reader_if.sv
// AXI3 read-address/read-data channels plus the outgoing valid/ready stream.
interface dma_stream_reader_if #(parameter int ADDR_W = 32);
    logic [ADDR_W-1:0] araddr;
    logic [3:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [63:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;
    logic [63:0]       stream_data;
    logic              stream_valid;
    logic              stream_ready;

    modport master (
        output araddr, arlen, arsize, arburst, arcache, arprot, arvalid, rready,
        output stream_data, stream_valid,
        input  arready, rdata, rresp, rlast, rvalid, stream_ready
    );
    modport slave (
        input  araddr, arlen, arsize, arburst, arcache, arprot, arvalid, rready,
        input  stream_data, stream_valid,
        output arready, rdata, rresp, rlast, rvalid, stream_ready
    );
endinterface

// File: rtl/dma_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
module dma_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [AW:0]      cnt;
    logic             do_wr, do_rd;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign count   = cnt;
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem[rptr];

    // Storage has no reset so it can map onto RAM.
    always_ff @(posedge clk)
        if (do_wr) mem[wptr] <= wr_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_wr) wptr <= wptr + AW'(1);
            if (do_rd) rptr <= rptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/dma_stream_reader.sv
// AXI3 read-master DMA: 16x64-bit bursts from a DDR region into a valid/ready stream.
// Optional sticky rresp error flag enabled by `define DMA_READ_RRESP_ERR_EN.
module dma_stream_reader
    import dma_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] start_address,
    input  logic [ADDR_W-1:0] end_address,
    output logic              finished,
`ifdef DMA_READ_RRESP_ERR_EN
    output logic              rresp_err,
`endif
    dma_stream_reader_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int OW = $clog2(FIFO_DEPTH / BURST_BEATS) + 1;
    localparam int SW = CW + 1;

    state_t            state;
    logic [ADDR_W-1:0] addr_q, end_q, next_addr;
    logic [OW-1:0]     outstanding;
    logic              arvalid_q, stop_pend;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty, fifo_full;
    logic              ar_fire, r_fire, rlast_fire, space_ok;
    logic [SW-1:0]     need;
    logic              unused_ok;

    assign ar_fire    = arvalid_q & bus.arready;
    assign r_fire     = bus.rvalid & bus.rready;
    assign rlast_fire = r_fire & bus.rlast;
    assign next_addr  = addr_q + ADDR_W'(BURST_BYTES);

    // Every outstanding burst holds a full 16-word reservation until its rlast.
    assign need     = SW'(fifo_count) + (SW'(outstanding) << 4) + SW'(BURST_BEATS);
    assign space_ok = (need <= SW'(FIFO_DEPTH));

    assign bus.araddr       = addr_q;
    assign bus.arlen        = LEN_16;
    assign bus.arsize       = SIZE_8B;
    assign bus.arburst      = BURST_INCR;
    assign bus.arcache      = CACHE_DEFAULT;
    assign bus.arprot       = PROT_DEFAULT;
    assign bus.arvalid      = arvalid_q;
    assign bus.rready       = (outstanding != '0);
    assign bus.stream_valid = ~fifo_empty;
    assign unused_ok        = ^{fifo_full, bus.rresp};

    dma_sync_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (r_fire),
        .wr_data (bus.rdata),
        .rd_en   (bus.stream_valid & bus.stream_ready),
        .rd_data (bus.stream_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            end_q       <= '0;
            outstanding <= '0;
            arvalid_q   <= 1'b0;
            stop_pend   <= 1'b0;
            finished    <= 1'b0;
`ifdef DMA_READ_RRESP_ERR_EN
            rresp_err   <= 1'b0;
`endif
        end else begin
            case ({ar_fire, rlast_fire})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: outstanding <= outstanding;
            endcase
`ifdef DMA_READ_RRESP_ERR_EN
            if (r_fire && bus.rresp != 2'b00) rresp_err <= 1'b1;
`endif
            case (state)
                IDLE: if (start) begin
                    addr_q    <= start_address;
                    end_q     <= end_address;
                    finished  <= 1'b0;
                    stop_pend <= 1'b0;
                    state     <= RUN;
`ifdef DMA_READ_RRESP_ERR_EN
                    rresp_err <= 1'b0;
`endif
                end
                RUN: begin
                    // A pending AR is never withdrawn; a stop waits for its handshake.
                    if (ar_fire) begin
                        arvalid_q <= 1'b0;
                        addr_q    <= next_addr;
                        if (stop || stop_pend || next_addr == end_q) state <= DRAIN;
                    end else if (arvalid_q) begin
                        if (stop) stop_pend <= 1'b1;
                    end else if (stop || stop_pend) begin
                        state <= DRAIN;
                    end else if (space_ok) begin
                        arvalid_q <= 1'b1;
                    end
                end
                DRAIN: if (outstanding == '0 && fifo_empty) begin
                    state    <= IDLE;
                    finished <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_stream_reader.sv
// Directed bench for dma_stream_reader: AXI slave model, stream sink and transfer-level scoreboard.
module tb_dma_stream_reader;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst, start, stop;
    logic [31:0] start_address, end_address;
    logic        finished;
`ifdef DMA_READ_RRESP_ERR_EN
    logic        rresp_err;
`endif

    dma_stream_reader_if #(.ADDR_W(32)) bus ();

    dma_stream_reader #(.ADDR_W(32), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stop          (stop),
        .start_address (start_address),
        .end_address   (end_address),
        .finished      (finished),
`ifdef DMA_READ_RRESP_ERR_EN
        .rresp_err     (rresp_err),
`endif
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    bit sink_ready = 1'b1;
    bit ar_block   = 1'b0;
    int stop_at_ar = -1;
    int stop_cyc   = -1;
    int err_at     = -1;
    int cyc        = 0;

    logic [31:0] base;
    int          ar_count, words_recv, words_popped;
    logic [31:0] ar_log[$];
    logic [63:0] first_word;
    logic [63:0] beat_q[$];
    bit          last_q[$];
    bit          p_ar, p_hold_ar, p_hold_s;
    logic [31:0] p_araddr;
    logic [63:0] p_sdata;

    // Memory content: each 64-bit word carries its own byte address.
    function automatic logic [63:0] mk(input logic [31:0] a);
        return {a, ~a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Slave, sink and compare process: all on the falling edge.
    initial begin
        bit ar_done;
        stop = 1'b0;
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rlast = 1'b0;
        bus.rresp = 2'b00; bus.stream_ready = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                beat_q.delete(); last_q.delete(); ar_log.delete();
                ar_count = 0; words_recv = 0; words_popped = 0;
                p_ar = 0; p_hold_ar = 0; p_hold_s = 0;
                stop = 1'b0; bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.arready = 1'b0;
                bus.stream_ready = sink_ready;
            end else begin
                if (start) begin
                    base = start_address;
                    ar_count = 0; words_recv = 0; words_popped = 0;
                    ar_log.delete();
                end
                ar_done = p_ar;
                if (p_ar) begin
                    chk("ar_addr", 64'(p_araddr), 64'(base + 32'(ar_count * 128)));
                    ar_log.push_back(p_araddr);
                    for (int i = 0; i < 16; i++) begin
                        beat_q.push_back(mk(p_araddr + 32'(i * 8)));
                        last_q.push_back(i == 15);
                    end
                    ar_count++;
                end
                chk("stream_valid", 64'(bus.stream_valid), 64'((words_recv - words_popped) > 0));
                chk("no_overflow", 64'((words_recv - words_popped) + beat_q.size() <= DEPTH), 64'(1));
                if (p_hold_ar) chk("ar_hold", 64'({bus.arvalid, bus.araddr}), 64'({1'b1, p_araddr}));
                if (p_hold_s)  chk("s_hold", bus.stream_data, p_sdata);
                if (p_hold_s)  chk("s_hold_vld", 64'(bus.stream_valid), 64'(1));

                stop = (stop_cyc == cyc) || (ar_done && stop_at_ar == ar_count);
                bus.arready = !ar_block;
                bus.rvalid  = beat_q.size() > 0;
                bus.rdata   = bus.rvalid ? beat_q[0] : 64'h0;
                bus.rlast   = bus.rvalid ? last_q[0] : 1'b0;
                bus.rresp   = (bus.rvalid && words_recv == err_at) ? 2'b10 : 2'b00;
                bus.stream_ready = sink_ready;

                p_ar = bus.arvalid & bus.arready;
                p_araddr = bus.araddr;
                if (p_ar)
                    chk("ar_const", 64'({bus.arlen, bus.arsize, bus.arburst, bus.arcache, bus.arprot}),
                        64'({4'hF, 3'b011, 2'b01, 4'b0011, 3'b000}));
                if (bus.rvalid & bus.rready) begin
                    void'(beat_q.pop_front());
                    void'(last_q.pop_front());
                    words_recv++;
                end
                p_hold_ar = bus.arvalid & !bus.arready;
                p_hold_s  = bus.stream_valid & !bus.stream_ready;
                p_sdata   = bus.stream_data;
                if (bus.stream_valid & bus.stream_ready) begin
                    chk("data", bus.stream_data, mk(base + 32'(words_popped * 8)));
                    if (words_popped == 0) first_word = bus.stream_data;
                    words_popped++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic kick(input logic [31:0] a, input logic [31:0] e);
        start_address = a;
        end_address   = e;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("finished_clr", 64'(finished), 64'(0));
    endtask

    task automatic wait_done(input int exp_words);
        for (int i = 0; i < 4000; i++) begin
            if (finished) break;
            tick();
        end
        chk("finished", 64'(finished), 64'(1));
        chk("words_out", 64'(words_popped), 64'(exp_words));
        repeat (2) tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_address = '0; end_address = '0;
        repeat (3) tick();
        chk("rst_arvalid", 64'(bus.arvalid), 64'(0));
        chk("rst_rready", 64'(bus.rready), 64'(0));
        chk("rst_svalid", 64'(bus.stream_valid), 64'(0));
        chk("rst_finished", 64'(finished), 64'(0));
`ifdef DMA_READ_RRESP_ERR_EN
        chk("rst_err", 64'(rresp_err), 64'(0));
`endif
        rst = 1'b0;
        repeat (2) tick();

        // Two bursts, everything always ready.
        kick(32'h1000_0000, 32'h1000_0100);
        wait_done(32);
        chk("t1_ar_count", 64'(ar_count), 64'(2));
        chk("t1_ar0", 64'(ar_log[0]), 64'h1000_0000);
        chk("t1_ar1", 64'(ar_log[1]), 64'h1000_0080);
        chk("t1_word0", first_word, 64'h1000_0000_EFFF_FFFF);

        // Stalled sink: reservations stop AR issue at 4 bursts.
        sink_ready = 1'b0;
        kick(32'h2000_0000, 32'h2000_0800);
        repeat (200) tick();
        chk("t2_ar_count", 64'(ar_count), 64'(4));
        chk("t2_arvalid", 64'(bus.arvalid), 64'(0));
        chk("t2_recv", 64'(words_recv), 64'(64));
        sink_ready = 1'b1;
        wait_done(256);
        chk("t2_ar_total", 64'(ar_count), 64'(16));

        // Stop the cycle after the 2nd AR handshake.
        stop_at_ar = 2;
        kick(32'h3000_0000, 32'h3000_0400);
        wait_done(32);
        chk("t3_ar_count", 64'(ar_count), 64'(2));
        stop_at_ar = -1;

        // arready held low, stop arrives while AR pending.
        ar_block = 1'b1;
        kick(32'h4000_0000, 32'h4000_0400);
        stop_cyc = cyc + 5;
        repeat (20) tick();
        chk("t4_ar_none", 64'(ar_count), 64'(0));
        chk("t4_arvalid", 64'(bus.arvalid), 64'(1));
        chk("t4_araddr", 64'(bus.araddr), 64'h4000_0000);
        ar_block = 1'b0;
        wait_done(16);
        chk("t4_ar_count", 64'(ar_count), 64'(1));
        stop_cyc = -1;

        // Reset mid-burst, then a clean transfer.
        kick(32'h5000_0000, 32'h5000_0400);
        for (int i = 0; i < 500 && words_recv < 20; i++) tick();
        chk("t5_midburst", 64'(words_recv >= 20), 64'(1));
        rst = 1'b1;
        tick();
        chk("t5_arvalid", 64'(bus.arvalid), 64'(0));
        chk("t5_svalid", 64'(bus.stream_valid), 64'(0));
        chk("t5_rready", 64'(bus.rready), 64'(0));
        chk("t5_finished", 64'(finished), 64'(0));
        tick();
        rst = 1'b0;
        repeat (2) tick();
        kick(32'h5100_0000, 32'h5100_0100);
        wait_done(32);
        chk("t5_ar_count", 64'(ar_count), 64'(2));

`ifdef DMA_READ_RRESP_ERR_EN
        // One SLVERR beat: sticky flag, data still forwarded.
        err_at = 5;
        kick(32'h6000_0000, 32'h6000_0100);
        wait_done(32);
        chk("t6_err_set", 64'(rresp_err), 64'(1));
        err_at = -1;
        kick(32'h6100_0000, 32'h6100_0080);
        chk("t6_err_clr", 64'(rresp_err), 64'(0));
        wait_done(16);
        chk("t6_err_stay", 64'(rresp_err), 64'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
